button_event_decoder: RTL and testbench

- Input-side counterpart of the clock's display path: turns raw, bouncing, active-low push buttons into the single-cycle increment/decrement strobes and the 2-bit mode register consumed by the time-keeping block.
- Sits between the board pins and the time block, on the divided clock domain.
- Replaces ad-hoc edge detection with synchronization, debounce, auto-repeat and mutual-exclusion rules.

---
 rtl/button_event_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_button_event_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns the three raw, bouncing, active-low push buttons of the clock into
// clean control events for the time-keeping block:
//   - two-flop synchronizer and counter-based debounce per button
//   - one press FSM each for increase/decrease (IDLE, HOLD, REPEAT, BLOCKED)
//   - a 2-bit mode register stepped by the mode button
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   : holding increase/decrease auto-repeats (delay, then fixed rate)
//   undefined : exactly one strobe per debounced press, no repeat counter
//
// Ports:
//   clk         in   divided system clock (1 MHz nominal)
//   reset       in   asynchronous, active-high reset
//   increase_n  in   raw increase button, active-low, asynchronous
//   decrease_n  in   raw decrease button, active-low, asynchronous
//   sw_n        in   raw mode button, active-low, asynchronous
//   increment   out  one-cycle strobe: add one to the selected field
//   decrement   out  one-cycle strobe: subtract one from the selected field
//   mode        out  00 run, 01 set hour, 10 set minute, 11 set second
//   mode_pulse  out  one-cycle strobe coinciding with a mode change
module button_event_decoder #(
  parameter int DEBOUNCE_CYC     = 20000,
  parameter int REPEAT_DELAY_CYC = 500000,
  parameter int REPEAT_RATE_CYC  = 250000,
  parameter int CNT_W            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       increase_n,
  input  logic       decrease_n,
  input  logic       sw_n,
  output logic       increment,
  output logic       decrement,
  output logic [1:0] mode,
  output logic       mode_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    REPEAT  = 2'd2,
    BLOCKED = 2'd3
  } press_state_t;

  // Bit order everywhere: 0 = increase, 1 = decrease, 2 = mode.
  logic [2:0] raw_n;
  logic [2:0] press_edge;
  logic [1:0] db_level;
  logic [1:0] pressed;
  logic [1:0] is_blocked;
  logic [1:0] strobe;

  assign raw_n = {sw_n, decrease_n, increase_n};

  // ---------------------------------------------------------------------------
  // Synchronizer + debounce, one per button
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             db_reg;
      logic             db_prev_reg;
      logic [CNT_W-1:0] db_cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          db_reg      <= 1'b1;
          db_prev_reg <= 1'b1;
          db_cnt_reg  <= '0;
        end else begin
          sync1_reg   <= raw_n[gi];
          sync2_reg   <= sync1_reg;
          db_prev_reg <= db_reg;
          // Any return to the accepted level restarts the stability count,
          // so a glitch must persist DEBOUNCE_CYC cycles to be accepted.
          if (sync2_reg == db_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            db_reg     <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + CNT_ONE;
          end
        end
      end

      assign press_edge[gi] = db_prev_reg & ~db_reg;

      if (gi < 2) begin : g_lvl
        assign db_level[gi] = db_reg;
      end
    end
  endgenerate

  assign pressed = ~db_level;

  // ---------------------------------------------------------------------------
  // Press FSMs for increase (0) and decrease (1)
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 2; gi++) begin : g_press
      press_state_t state_reg, state_next;
      logic         strobe_reg, strobe_next;
      logic         block_me;
`ifdef BTN_AUTOREPEAT_EN
      logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
`endif

      // Both held together blocks both FSMs. A button whose partner is
      // already parked in BLOCKED is not blocked again, so a fresh press of
      // the released partner is honoured while the other waits for release.
      assign block_me = pressed[0] & pressed[1] & ~is_blocked[1-gi];

      always_comb begin
        state_next  = state_reg;
        strobe_next = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_cnt_next = rpt_cnt_reg;
`endif
        case (state_reg)
          IDLE: begin
            if (block_me) begin
              state_next = BLOCKED;
            end else if (press_edge[gi]) begin
              state_next  = HOLD;
              strobe_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rpt_cnt_next = '0;
`endif
            end
          end
          HOLD: begin
            if (block_me) begin
              state_next = BLOCKED;
            end else if (!pressed[gi]) begin
              state_next = IDLE;
`ifdef BTN_AUTOREPEAT_EN
            end else if (rpt_cnt_reg == DELAY_LAST) begin
              state_next   = REPEAT;
              strobe_next  = 1'b1;
              rpt_cnt_next = '0;
            end else begin
              rpt_cnt_next = rpt_cnt_reg + CNT_ONE;
`endif
            end
          end
`ifdef BTN_AUTOREPEAT_EN
          REPEAT: begin
            // Release wins over a coinciding repeat tick.
            if (block_me) begin
              state_next = BLOCKED;
            end else if (!pressed[gi]) begin
              state_next = IDLE;
            end else if (rpt_cnt_reg == RATE_LAST) begin
              strobe_next  = 1'b1;
              rpt_cnt_next = '0;
            end else begin
              rpt_cnt_next = rpt_cnt_reg + CNT_ONE;
            end
          end
`endif
          BLOCKED: begin
            if (!pressed[gi]) begin
              state_next = IDLE;
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg  <= IDLE;
          strobe_reg <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_reg <= '0;
`endif
        end else begin
          state_reg  <= state_next;
          strobe_reg <= strobe_next;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_reg <= rpt_cnt_next;
`endif
        end
      end

      assign is_blocked[gi] = (state_reg == BLOCKED);
      assign strobe[gi]     = strobe_reg;
    end
  endgenerate

  assign increment = strobe[0];
  assign decrement = strobe[1];

  // ---------------------------------------------------------------------------
  // Mode register: steps on each debounced mode-button press
  // ---------------------------------------------------------------------------
  logic [1:0] mode_reg;
  logic       mode_pulse_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg       <= 2'b00;
      mode_pulse_reg <= 1'b0;
    end else begin
      mode_pulse_reg <= press_edge[2];
      if (press_edge[2]) begin
        mode_reg <= mode_reg + 2'd1;
      end
    end
  end

  assign mode       = mode_reg;
  assign mode_pulse = mode_pulse_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with short timing parameters
// (debounce 4, repeat delay 20, repeat rate 8). Expected strobes are pushed
// to a queue with the cycle they must appear in; a monitor on the falling
// edge pops and compares every strobe the DUT presents.
module tb_button_event_decoder;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       increase_n;
  logic       decrease_n;
  logic       sw_n;
  logic       increment;
  logic       decrement;
  logic [1:0] mode;
  logic       mode_pulse;

  button_event_decoder #(
    .DEBOUNCE_CYC    (DEB),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC (8),
    .CNT_W           (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .increase_n(increase_n),
    .decrease_n(decrease_n),
    .sw_n      (sw_n),
    .increment (increment),
    .decrement (decrement),
    .mode      (mode),
    .mode_pulse(mode_pulse)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 increment, 1 decrement, 2 mode change
    int         cycle;
    logic [1:0] mval;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic expect_ev(input int kind, input int cycle, input logic [1:0] mval);
    ev_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.mval  = mval;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cycle=%0d mode=%0d, required no event",
               kind, cyc, mode);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cycle != cyc || (kind == 2 && e.mval != mode)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cycle=%0d mode=%0d, required kind=%0d cycle=%0d mode=%0d",
                 kind, cyc, mode, e.kind, e.cycle, e.mval);
      end else begin
        $display("ok   event kind=%0d cycle=%0d mode=%0d", kind, cyc, mode);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (increment && decrement) begin
        n_checks++;
        n_fail++;
        $display("FAIL exclusive: got increment=1 decrement=1 at cycle %0d, required at most one", cyc);
      end
      if (increment)  check_event(0);
      if (decrement)  check_event(1);
      if (mode_pulse) check_event(2);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d expected events missing (next cycle %0d), required 0",
               name, exp_q.size(), exp_q[0].cycle);
      exp_q.delete();
    end else begin
      $display("ok   %s: all expected events seen", name);
    end
  endtask

  task automatic check_val(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  int         t0, t1, tr;
  logic [1:0] m;

  initial begin
    reset      = 1'b1;
    increase_n = 1'b1;
    decrease_n = 1'b1;
    sw_n       = 1'b1;
    step(3);
    check_val("reset_mode", int'(mode), 0);
    check_val("reset_increment", int'(increment), 0);
    check_val("reset_decrement", int'(decrement), 0);
    check_val("reset_mode_pulse", int'(mode_pulse), 0);
    reset = 1'b0;

    // Idle: nothing for 100 cycles
    step(100);
    check_drained("idle_quiet");

    // Single clean press of increase, 10 cycles
    t0 = cyc;
    increase_n = 1'b0;
    expect_ev(0, t0 + LAT, 2'b00);
    step(10);
    increase_n = 1'b1;
    step(20);
    check_drained("inc_single");

    // Bouncing: 3 low / 1 high, never stable long enough
    for (int i = 0; i < 10; i++) begin
      increase_n = 1'b0;
      step(3);
      increase_n = 1'b1;
      step(1);
    end
    step(20);
    check_drained("inc_glitch");

    // Decrease held 60 cycles
    t0 = cyc;
    decrease_n = 1'b0;
    expect_ev(1, t0 + 7, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(1, t0 + 27, 2'b00);
    expect_ev(1, t0 + 35, 2'b00);
    expect_ev(1, t0 + 43, 2'b00);
    expect_ev(1, t0 + 51, 2'b00);
    expect_ev(1, t0 + 59, 2'b00);
`endif
    step(60);
    decrease_n = 1'b1;
    step(30);
    check_drained("dec_hold");

    // Mode button: 5 presses of 10 low / 10 high
    m = 2'b00;
    for (int i = 0; i < 5; i++) begin
      t0 = cyc;
      sw_n = 1'b0;
      m = m + 2'd1;
      expect_ev(2, t0 + LAT, m);
      step(10);
      sw_n = 1'b1;
      step(10);
    end
    step(10);
    check_drained("mode_cycle");

    // Both pressed together: blocked; decrease re-press honoured
    t0 = cyc;
    increase_n = 1'b0;
    decrease_n = 1'b0;
    step(40);
    decrease_n = 1'b1;
    step(10);
    t1 = cyc;
    decrease_n = 1'b0;
    expect_ev(1, t1 + LAT, 2'b00);
    step(12);
    decrease_n = 1'b1;
    step(10);
    increase_n = 1'b1;
    step(20);
    check_drained("both_blocked");

    // Reset during a held increase
    t0 = cyc;
    increase_n = 1'b0;
    expect_ev(0, t0 + 7, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(0, t0 + 27, 2'b00);
    expect_ev(0, t0 + 35, 2'b00);
`endif
    step(38);
    reset = 1'b1;
    step(3);
    check_val("midhold_reset_increment", int'(increment), 0);
    reset = 1'b0;
    tr = cyc;
    check_val("midhold_reset_mode", int'(mode), 0);
    expect_ev(0, tr + LAT, 2'b00);
    step(12);
    increase_n = 1'b1;
    step(20);
    check_drained("reset_midhold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
